// File: rtl/sram_rd_scheduler_if.sv
// Request, response and SRAM read-port bundle for sram_rd_scheduler.
// The scheduler uses the slave side; requesters and the SRAM model use the master side.
interface sram_rd_scheduler_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [LEN_WIDTH-1:0]  req0_len;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [LEN_WIDTH-1:0]  req1_len;

  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic                  rsp0_last;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;
  logic                  rsp1_last;

  logic [ADDR_WIDTH-1:0] mem_read_address;
  logic                  mem_read_enable;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_read_valid;

  modport slave (
    input  req0_valid, req0_addr, req0_len,
    input  req1_valid, req1_addr, req1_len,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_last,
    output rsp1_valid, rsp1_data, rsp1_last,
    output mem_read_address, mem_read_enable,
    input  mem_read_data, mem_read_valid
  );

  modport master (
    output req0_valid, req0_addr, req0_len,
    output req1_valid, req1_addr, req1_len,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_last,
    input  rsp1_valid, rsp1_data, rsp1_last,
    input  mem_read_address, mem_read_enable,
    output mem_read_data, mem_read_valid
  );
endinterface

// File: rtl/sram_rd_scheduler.sv
// Two-requester round-robin burst read scheduler for a single-port SRAM with
// one-cycle registered read data; responses are steered back by a delayed owner tag.
module sram_rd_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sram_rd_scheduler_if.slave   bus,
  output logic                 busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count;
  logic                  owner;
  logic                  ptr;
  logic                  tag_d;
  logic                  last_d;
  logic                  pend;
  logic                  grant0;
  logic                  grant1;
  logic                  beat_last;
  logic                  rsp_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  assign beat_last = (count == len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
        if (grant0 || grant1) state_next = BURST;
      end
      BURST: begin
        if (beat_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // count is left at len after a burst so the address output holds in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base   <= '0;
      len_q  <= '0;
      count  <= '0;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      tag_d  <= 1'b0;
      last_d <= 1'b0;
      pend   <= 1'b0;
    end else begin
      pend <= (state == BURST);
      if (state == BURST) begin
        tag_d  <= owner;
        last_d <= beat_last;
        if (!beat_last) count <= count + 1'b1;
      end else if (grant0 || grant1) begin
        base  <= grant1 ? bus.req1_addr : bus.req0_addr;
        len_q <= grant1 ? bus.req1_len  : bus.req0_len;
        count <= '0;
        owner <= grant1;
        ptr   <= ~grant1;
      end
    end
  end

  assign bus.req0_ready       = grant0 && reset_n;
  assign bus.req1_ready       = grant1 && reset_n;
  assign bus.mem_read_enable  = (state == BURST);
  assign bus.mem_read_address = base + ADDR_WIDTH'(count);

  // pend masks read data still in flight from a burst aborted by reset
  assign rsp_hit        = bus.mem_read_valid && pend;
  assign rd_data        = bus.mem_read_data;
  assign bus.rsp0_valid = rsp_hit && !tag_d;
  assign bus.rsp1_valid = rsp_hit &&  tag_d;
  assign bus.rsp0_last  = last_d && bus.rsp0_valid;
  assign bus.rsp1_last  = last_d && bus.rsp1_valid;
  assign bus.rsp0_data  = rd_data;
  assign bus.rsp1_data  = rd_data;

  assign busy = (state == BURST) || pend;

endmodule
